layer_sequencer: RTL

//  Drives one layer of neural-network nodes that share one control bus: cnt_val, start, reset_acc.
//  Per inference: clears the node accumulators, steps cnt_val through every input index,

---
 rtl/ann_pkg.sv | 19 +
 rtl/serial_argmax.sv | 59 +++++
 rtl/layer_sequencer.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/ann_pkg.sv
// Shared types and defaults for the neural-network layer datapath.
// Used by the layer sequencer, its argmax helper and the node models.
package ann_pkg;

    localparam int DEF_IMAGE_SIZE = 64;
    localparam int DEF_NUM_NODES  = 10;

    typedef logic [15:0] fixed16_t;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        ACCUM,
        SETTLE,
        ARGMAX,
        DONE
    } seq_state_t;

endpackage

// File: rtl/serial_argmax.sv
// Serial argmax: load seeds best with element 0, then each scan cycle
// compares one element (j = 1..N-1), signed, ties keep the lower index.
// Ports: load/first seed the scan, scan steps it, vals is the array being
// scanned (held stable by the caller), idx is the running winner and
// last is high while the final element is being compared.
module serial_argmax
    import ann_pkg::*;
#(
    parameter int N     = DEF_NUM_NODES,
    parameter int IDX_W = 4
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 load,
    input  fixed16_t             first,
    input  logic                 scan,
    input  fixed16_t [N-1:0]     vals,
    output logic     [IDX_W-1:0] idx,
    output logic                 last
);

    fixed16_t         best_q, best_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W-1:0] j_q, j_d;

    always_comb begin
        best_d = best_q;
        idx_d  = idx_q;
        j_d    = j_q;
        if (load) begin
            best_d = first;
            idx_d  = '0;
            j_d    = IDX_W'(1);
        end else if (scan) begin
            // strict greater-than keeps the lower index on ties
            if ($signed(vals[j_q]) > $signed(best_q)) begin
                best_d = vals[j_q];
                idx_d  = j_q;
            end
            j_d = j_q + IDX_W'(1);
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            best_q <= '0;
            idx_q  <= '0;
            j_q    <= IDX_W'(1);
        end else begin
            best_q <= best_d;
            idx_q  <= idx_d;
            j_q    <= j_d;
        end
    end

    assign idx  = idx_q;
    assign last = (j_q == IDX_W'(N - 1));

endmodule

// File: rtl/layer_sequencer.sv
// Control sequencer for one layer of nodes sharing cnt_val/start/reset_acc:
// clear, sweep inputs, hold, capture node outputs, serial argmax, present.
// Ports: go_valid/go_ready request an inference, cnt_val/start/reset_acc
// drive the node bus, node_out is sampled into result, class_idx is the
// argmax of result, out_valid/out_ready hand the result off, busy != IDLE.
module layer_sequencer
    import ann_pkg::*;
#(
    parameter int IMAGE_SIZE = DEF_IMAGE_SIZE,
    parameter int NUM_NODES  = DEF_NUM_NODES,
    parameter int CNT_W      = 7,
    parameter int IDX_W      = 4
) (
    input  logic                         clk,
    input  logic                         n_rst,
    input  logic                         go_valid,
    output logic                         go_ready,
    output logic     [CNT_W-1:0]         cnt_val,
    output logic                         start,
    output logic                         reset_acc,
    input  fixed16_t [NUM_NODES-1:0]     node_out,
    output fixed16_t [NUM_NODES-1:0]     result,
    output logic     [IDX_W-1:0]         class_idx,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         busy
);

    seq_state_t               state_q, state_d;
    logic     [CNT_W-1:0]     cnt_q, cnt_d;
    logic                     start_q, start_d;
    logic                     reset_acc_q, reset_acc_d;
    fixed16_t [NUM_NODES-1:0] result_q, result_d;
    logic                     out_valid_q, out_valid_d;

    logic am_load;
    logic am_scan;
    logic am_last;

    // outputs are registered, so each state computes the values
    // the bus must carry during the following state
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        start_d     = start_q;
        reset_acc_d = 1'b0;
        result_d    = result_q;
        out_valid_d = out_valid_q;
        am_load     = 1'b0;
        am_scan     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (go_valid) begin
                    state_d     = CLEAR;
                    reset_acc_d = 1'b1;
                    start_d     = 1'b1;
                    cnt_d       = '0;
                end
            end
            CLEAR: begin
                state_d = ACCUM;
                start_d = 1'b0;
                cnt_d   = '0;
            end
            ACCUM: begin
                if (cnt_q == CNT_W'(IMAGE_SIZE - 1)) begin
                    state_d = SETTLE;
                    start_d = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            SETTLE: begin
                // accumulators are frozen; sample them and seed the scan
                result_d = node_out;
                am_load  = 1'b1;
                state_d  = ARGMAX;
            end
            ARGMAX: begin
                am_scan = 1'b1;
                if (am_last) begin
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                start_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            start_q     <= 1'b1;
            reset_acc_q <= 1'b0;
            result_q    <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            start_q     <= start_d;
            reset_acc_q <= reset_acc_d;
            result_q    <= result_d;
            out_valid_q <= out_valid_d;
        end
    end

    // argmax scans the captured result; node_out[0] seeds it because
    // result is being loaded on the same edge
    serial_argmax #(
        .N     (NUM_NODES),
        .IDX_W (IDX_W)
    ) u_argmax (
        .clk   (clk),
        .n_rst (n_rst),
        .load  (am_load),
        .first (node_out[0]),
        .scan  (am_scan),
        .vals  (result_q),
        .idx   (class_idx),
        .last  (am_last)
    );

    assign go_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign cnt_val   = cnt_q;
    assign start     = start_q;
    assign reset_acc = reset_acc_q;
    assign result    = result_q;
    assign out_valid = out_valid_q;

endmodule
